// File: rtl/raymarch_frame_scheduler.sv
// Raster-order pixel scheduler: issues each (x,y) to the raymarcher, waits for its colour
// (or a watchdog fallback), and writes the RGB565 result to the framebuffer port.
module raymarch_frame_scheduler #(
  parameter int          WIDTH          = 300,
  parameter int          HEIGHT         = 300,
  parameter int          ADDR_W         = 17,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [15:0] FALLBACK_RGB   = 16'hF81F
) (
  input  logic              clk_pixel_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic              busy_out,
  output logic [32:0]       curr_x_out,
  output logic [32:0]       curr_y_out,
  output logic              pixel_req_out,
  input  logic [7:0]        red_in,
  input  logic [7:0]        green_in,
  input  logic [7:0]        blue_in,
  input  logic              pixel_done_in,
  output logic              fb_we_out,
  output logic [ADDR_W-1:0] fb_addr_out,
  output logic [15:0]       fb_data_out,
  output logic              frame_done_out,
  output logic [15:0]       timeout_cnt_out
);

  localparam int              TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0]     X_MAX     = 33'(WIDTH - 1);
  localparam logic [32:0]     Y_MAX     = 33'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [32:0]       r_x;
  logic [32:0]       r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [15:0]       r_fb_data;
  logic [15:0]       r_timeout_cnt;
  logic [TW-1:0]     r_timer;
  logic              w_timeout;
  logic              w_last_pixel;
  logic [15:0]       w_rgb565;
  logic              w_unused;

  assign w_rgb565     = {red_in[7:3], green_in[7:2], blue_in[7:3]};
  assign w_unused     = ^{red_in[2:0], green_in[1:0], blue_in[2:0]};
  assign w_timeout    = (r_timer == TIMER_MAX);
  assign w_last_pixel = (r_x == X_MAX) && (r_y == Y_MAX);

  assign curr_x_out      = r_x;
  assign curr_y_out      = r_y;
  assign fb_addr_out     = r_fb_addr;
  assign fb_data_out     = r_fb_data;
  assign timeout_cnt_out = r_timeout_cnt;

  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Handshake: pixel_req_out pulses for one cycle with curr_x/curr_y valid; the coordinate
  // stays put until pixel_done_in is seen in WAIT (or the watchdog fires). Done pulses at
  // any other time are stale and dropped.
  always_comb begin
    w_next         = r_state;
    busy_out       = 1'b1;
    pixel_req_out  = 1'b0;
    fb_we_out      = 1'b0;
    frame_done_out = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_out = 1'b0;
        if (start_in) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        pixel_req_out = 1'b1;
        w_next        = S_WAIT;
      end
      S_WAIT: begin
        if (pixel_done_in || w_timeout) w_next = S_WRITE;
      end
      S_WRITE: begin
        fb_we_out = 1'b1;
        w_next    = w_last_pixel ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        frame_done_out = 1'b1;
        w_next         = S_IDLE;
      end
      default: begin
        busy_out = 1'b0;
        w_next   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      r_x           <= '0;
      r_y           <= '0;
      r_addr        <= '0;
      r_fb_addr     <= '0;
      r_fb_data     <= '0;
      r_timeout_cnt <= '0;
      r_timer       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_x           <= '0;
            r_y           <= '0;
            r_addr        <= '0;
            r_timeout_cnt <= '0;
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT: begin
          // A real result beats the watchdog when both land in the same cycle.
          if (pixel_done_in) begin
            r_fb_data <= w_rgb565;
            r_fb_addr <= r_addr;
          end else if (w_timeout) begin
            r_fb_data <= FALLBACK_RGB;
            r_fb_addr <= r_addr;
            if (r_timeout_cnt != 16'hFFFF) r_timeout_cnt <= r_timeout_cnt + 16'd1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_WRITE: begin
          if (r_x < X_MAX) begin
            r_x <= r_x + 33'd1;
          end else begin
            r_x <= '0;
            if (r_y < Y_MAX) r_y <= r_y + 33'd1;
          end
          if (!w_last_pixel) r_addr <= r_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// Scoreboard bench for raymarch_frame_scheduler: a raymarcher model answers each request
// and queues the expected framebuffer write; a monitor pops and compares each write.
module tb_raymarch_frame_scheduler;

  localparam int          W  = 4;
  localparam int          H  = 3;
  localparam int          TO = 8;
  localparam int          N  = W * H;
  localparam int          AW = 17;
  localparam logic [15:0] FB = 16'hF81F;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_in, start_in, pixel_done_in;
  logic [7:0]    red_in, green_in, blue_in;
  logic          busy_out, pixel_req_out, fb_we_out, frame_done_out;
  logic [32:0]   curr_x_out, curr_y_out;
  logic [AW-1:0] fb_addr_out;
  logic [15:0]   fb_data_out, timeout_cnt_out;

  raymarch_frame_scheduler #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .TIMEOUT_CYCLES(TO), .FALLBACK_RGB(FB)
  ) dut (
    .clk_pixel_in   (clk),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .busy_out       (busy_out),
    .curr_x_out     (curr_x_out),
    .curr_y_out     (curr_y_out),
    .pixel_req_out  (pixel_req_out),
    .red_in         (red_in),
    .green_in       (green_in),
    .blue_in        (blue_in),
    .pixel_done_in  (pixel_done_in),
    .fb_we_out      (fb_we_out),
    .fb_addr_out    (fb_addr_out),
    .fb_data_out    (fb_data_out),
    .frame_done_out (frame_done_out),
    .timeout_cnt_out(timeout_cnt_out)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] rgb565(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int v;
    v = (int'(r) / 8) * 2048 + (int'(g) / 4) * 32 + int'(b) / 8;
    return 16'(v);
  endfunction

  // 0 = never answer; 1..TO = answered inside WAIT; >TO = arrives too late
  function automatic int pick_delay(input int m, input int i);
    case (m)
      0:       return 3;
      1:       return $urandom_range(1, 6);
      2: begin
        if (i == 5) return 0;
        if (i == 8) return TO;
        if (i == 3) return TO + 1;
        return $urandom_range(1, TO);
      end
      default: return $urandom_range(2, TO);
    endcase
  endfunction

  // scoreboard: {addr[31:0], data[15:0], write_cycle[31:0]} and {done_cycle[31:0], tcnt[15:0]}
  logic [79:0] exp_q[$];
  logic [47:0] done_q[$];

  int          mode = 0;
  bit          stale_en = 1'b0;
  bit          idle_noise = 1'b0;
  int          idx = 0;
  int          m_tcnt = 0;
  bit          pend = 1'b0;
  int unsigned fire = 0;
  logic [7:0]  pr, pg, pb;

  // raymarcher model
  always @(negedge clk) begin
    int          d;
    int          ex, ey;
    logic [15:0] ed;
    int unsigned wc;
    if (!rst_in) begin
      pend          = 1'b0;
      idx           = 0;
      m_tcnt        = 0;
      pixel_done_in = 1'b0;
      exp_q.delete();
      done_q.delete();
    end else begin
      pixel_done_in = 1'b0;
      if (pixel_req_out) begin
        ex = idx % W;
        ey = idx / W;
        check("req_x", 64'(curr_x_out), 64'(ex));
        check("req_y", 64'(curr_y_out), 64'(ey));
        if (idx == 0) m_tcnt = 0;
        d = pick_delay(mode, idx);
        if (mode == 0) begin
          pr = 8'(ex * 16); pg = 8'(ey * 16); pb = 8'h80;
        end else if (mode == 1 && idx == 0) begin
          pr = 8'hFF; pg = 8'hFF; pb = 8'hFF;
        end else if (mode == 1 && idx == 1) begin
          pr = 8'h08; pg = 8'h04; pb = 8'h08;
        end else if (mode == 1 && idx == 2) begin
          pr = 8'h07; pg = 8'h03; pb = 8'h07;
        end else begin
          pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom);
        end
        if (d >= 1 && d <= TO) begin
          ed = rgb565(pr, pg, pb);
          wc = cyc + 32'(d) + 1;
        end else begin
          ed = FB;
          wc = cyc + 32'(TO) + 1;
          m_tcnt++;
        end
        pend = (d > 0);
        fire = cyc + 32'(d);
        exp_q.push_back({32'(idx), ed, wc});
        if (idx == N - 1) begin
          done_q.push_back({32'(wc + 1), 16'(m_tcnt)});
          idx = 0;
        end else begin
          idx++;
        end
        if (stale_en) begin
          pixel_done_in = 1'b1;
          red_in = 8'($urandom); green_in = 8'($urandom); blue_in = 8'($urandom);
        end
      end else if (pend && cyc == fire) begin
        pixel_done_in = 1'b1;
        red_in = pr; green_in = pg; blue_in = pb;
        pend = 1'b0;
      end else if (idle_noise && !busy_out) begin
        pixel_done_in = 1'($urandom_range(0, 1));
        red_in = 8'($urandom); green_in = 8'($urandom); blue_in = 8'($urandom);
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    logic [79:0] e;
    logic [47:0] f;
    if (fb_we_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %04h expected no write", fb_addr_out, fb_data_out);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(fb_addr_out), 64'(e[79:48]));
        check("wr_data", 64'(fb_data_out), 64'(e[47:32]));
        check("wr_cycle", 64'(cyc), 64'(e[31:0]));
      end
    end
    if (frame_done_out) begin
      if (done_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame_done: got pulse expected none (cycle %0d)", cyc);
      end else begin
        f = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(f[47:16]));
        check("done_tcnt", 64'(timeout_cnt_out), 64'(f[15:0]));
        check("done_busy", 64'(busy_out), 64'd1);
      end
    end
  end

  // driver tasks
  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy_out), 64'd0);
    check({tag, "_req"}, 64'(pixel_req_out), 64'd0);
    check({tag, "_we"}, 64'(fb_we_out), 64'd0);
    check({tag, "_fdone"}, 64'(frame_done_out), 64'd0);
    check({tag, "_x"}, 64'(curr_x_out), 64'd0);
    check({tag, "_y"}, 64'(curr_y_out), 64'd0);
    check({tag, "_addr"}, 64'(fb_addr_out), 64'd0);
    check({tag, "_data"}, 64'(fb_data_out), 64'd0);
    check({tag, "_tcnt"}, 64'(timeout_cnt_out), 64'd0);
  endtask

  task automatic wait_frames(input int frames, input bit pulses);
    int seen;
    seen = 0;
    for (int k = 0; k < 3000 && seen < frames; k++) begin
      @(posedge clk); #1;
      if (frame_done_out) begin
        seen++;
        if (seen == frames) start_in = 1'b0;
      end else if (pulses) begin
        start_in = 1'($urandom_range(0, 1));
      end
    end
    start_in = 1'b0;
    check("frames_seen", 64'(seen), 64'(frames));
    @(posedge clk); #1;
    check("idle_busy", 64'(busy_out), 64'd0);
    check("queue_drained", 64'(exp_q.size() + done_q.size()), 64'd0);
  endtask

  task automatic run_frame(input bit pulses);
    @(posedge clk); #1 start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    wait_frames(1, pulses);
  endtask

  initial begin
    bit found;
    rst_in = 1'b0; start_in = 1'b0; pixel_done_in = 1'b0;
    red_in = '0; green_in = '0; blue_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_in = 1'b1;

    mode = 0;
    run_frame(1'b0);
    check("tcnt_clean", 64'(timeout_cnt_out), 64'd0);

    mode = 1;
    run_frame(1'b1);

    mode = 2; stale_en = 1'b1; idle_noise = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    run_frame(1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("tcnt_held", 64'(timeout_cnt_out), 64'(m_tcnt));
    stale_en = 1'b0; idle_noise = 1'b0;

    mode = 3;
    @(posedge clk); #1 start_in = 1'b1;
    wait_frames(3, 1'b0);

    mode = 4;
    @(posedge clk); #1 start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(posedge clk); #1;
      if (pixel_req_out && curr_x_out == 33'd3 && curr_y_out == 33'd1) found = 1'b1;
    end
    check("reach_pixel7", 64'(found), 64'd1);
    @(posedge clk); #1 rst_in = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    rst_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", 64'(busy_out), 64'd0);

    mode = 0;
    run_frame(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
